// File: rtl/wave_oscillator.sv
// Phase-accumulator oscillator: prescaled sample ticks advance a phase accumulator,
// and the top WIDTH phase bits are shaped into saw, pulse, triangle or ramp-down samples.
module wave_oscillator #(
   parameter int                WIDTH      = 8,
   parameter int                ACC_W      = 16,
   parameter int                SAMPLE_DIV = 150,
   parameter logic [ACC_W-1:0]  RESET_FREQ = '0
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              enable,
   input  logic              sync,
   input  logic              load,
   input  logic [ACC_W-1:0]  freq_word,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  pulse_width,
   output logic [WIDTH-1:0]  wave_out,
   output logic              sample_tick,
   output logic              wrap
);

   localparam int             CNT_W    = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

   localparam logic [1:0] MODE_SAW   = 2'b00;
   localparam logic [1:0] MODE_PULSE = 2'b01;
   localparam logic [1:0] MODE_TRI   = 2'b10;
   localparam logic [1:0] MODE_RAMP  = 2'b11;

   logic [CNT_W-1:0] count;
   logic [ACC_W-1:0] phase;
   logic [ACC_W-1:0] active_freq;
   logic [ACC_W-1:0] pend_freq;
   logic             pend_valid;

   logic             tick;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             apply_pend;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] wave_next;

   // A sync in the same cycle suppresses the tick entirely.
   assign tick  = enable & (count == CNT_LAST) & ~sync;
   assign sum   = {1'b0, phase} + {1'b0, active_freq};
   assign carry = sum[ACC_W];
   assign p     = phase[ACC_W-1 -: WIDTH];

   // Pending word lands on a wrap, or at once when the phase is not moving anyway.
   assign apply_pend = pend_valid & ((tick & carry) | (active_freq == '0) | ~enable);

   always_comb begin
      wave_next = '0;
      case (mode)
         MODE_SAW:   wave_next = p;
         MODE_PULSE: wave_next = (p < pulse_width) ? '1 : '0;
         MODE_TRI:   wave_next = p[WIDTH-1] ? ~{p[WIDTH-2:0], 1'b0} : {p[WIDTH-2:0], 1'b0};
         MODE_RAMP:  wave_next = ~p;
         default:    wave_next = p;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         count <= '0;
      end else if (sync) begin
         count <= '0;
      end else if (enable) begin
         if (count == CNT_LAST) count <= '0;
         else                   count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         phase       <= '0;
         sample_tick <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         sample_tick <= tick;
         wrap        <= tick & carry;
         if (sync)      phase <= '0;
         else if (tick) phase <= sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         active_freq <= RESET_FREQ;
         pend_freq   <= '0;
         pend_valid  <= 1'b0;
      end else begin
         if (load) pend_freq <= freq_word;
         if (sync) begin
            if (load)            active_freq <= freq_word;
            else if (pend_valid) active_freq <= pend_freq;
            pend_valid <= 1'b0;
         end else begin
            // A load racing the apply stays pending for the following wrap.
            if (apply_pend) active_freq <= pend_freq;
            pend_valid <= load | (pend_valid & ~apply_pend);
         end
      end
   end

   // Sample is shaped from the phase one cycle after it advanced.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wave_out <= '0;
      end else if (enable && sample_tick) begin
         wave_out <= wave_next;
      end
   end

endmodule

// File: tb/tb_wave_oscillator.sv
// Directed bench for wave_oscillator at WIDTH=8, ACC_W=16, SAMPLE_DIV=4.
module tb_wave_oscillator;

   localparam int WIDTH = 8;
   localparam int ACC_W = 16;

   logic             clk;
   logic             nRst;
   logic             enable;
   logic             sync;
   logic             load;
   logic [ACC_W-1:0] freq_word;
   logic [1:0]       mode;
   logic [WIDTH-1:0] pulse_width;
   logic [WIDTH-1:0] wave_out;
   logic             sample_tick;
   logic             wrap;

   int n_total = 0;
   int n_bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

   wave_oscillator #(
      .WIDTH(WIDTH), .ACC_W(ACC_W), .SAMPLE_DIV(4), .RESET_FREQ('0)
   ) dut (
      .clk(clk), .nRst(nRst), .enable(enable), .sync(sync), .load(load),
      .freq_word(freq_word), .mode(mode), .pulse_width(pulse_width),
      .wave_out(wave_out), .sample_tick(sample_tick), .wrap(wrap)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic pulse_load(input logic [ACC_W-1:0] w);
      load = 1'b1; freq_word = w;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic sync_load(input logic [ACC_W-1:0] w);
      sync = 1'b1; load = 1'b1; freq_word = w;
      @(negedge clk);
      sync = 1'b0; load = 1'b0;
   endtask

   // waits for the next sample_tick, then reads the sample one cycle later
   task automatic get_sample(output logic [WIDTH-1:0] w, output logic wr, output int n);
      logic found;
      found = 1'b0; n = 0; wr = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         n++;
         if (sample_tick) begin
            found = 1'b1;
            wr = wrap;
         end
      end
      if (!found) check("tick_timeout", 32'd0, 32'd1);
      @(negedge clk);
      n++;
      w = wave_out;
   endtask

   initial begin
      logic [WIDTH-1:0] w, prev, step, ex;
      logic             wr, after_wrap;
      int               n, err, err2, cnt_a, cnt_b;

      nRst = 1'b0; enable = 1'b0; sync = 1'b0; load = 1'b0;
      freq_word = '0; mode = 2'b00; pulse_width = '0;
      repeat (3) @(negedge clk);
      check("rst_wave", 32'(wave_out), 32'h0);
      check("rst_tick", 32'(sample_tick), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);
      nRst = 1'b1;
      @(negedge clk);

      // 1: saw at 0x0100
      enable = 1'b1;
      pulse_load(16'h0100);
      get_sample(w, wr, n);
      check("saw_first", 32'(w), 32'h01);
      err = 0; err2 = 0; cnt_a = 0; cnt_b = 0;
      for (int k = 2; k <= 512; k++) begin
         get_sample(w, wr, n);
         if (w != WIDTH'(k % 256)) err++;
         if (n != 4) err2++;
         if (wr) begin
            cnt_a++;
            if (w != 8'h00) cnt_b++;
         end
      end
      check("saw_values", 32'(err), 32'd0);
      check("saw_tick_period", 32'(err2), 32'd0);
      check("saw_wrap_count", 32'(cnt_a), 32'd2);
      check("saw_wrap_at_zero", 32'(cnt_b), 32'd0);

      // 2: load 0x0200 mid-cycle, step changes only after the wrap
      for (int k = 0; k < 80; k++) get_sample(w, wr, n);
      check("saw_pre_load", 32'(w), 32'h50);
      pulse_load(16'h0200);
      prev = w; after_wrap = 1'b0; err = 0; cnt_a = 0;
      for (int k = 0; k < 196; k++) begin
         get_sample(w, wr, n);
         step = w - prev;
         if (step != (after_wrap ? 8'd2 : 8'd1)) err++;
         if (wr) begin
            cnt_a++;
            after_wrap = 1'b1;
         end
         prev = w;
      end
      check("defer_steps", 32'(err), 32'd0);
      check("defer_wraps", 32'(cnt_a), 32'd1);

      // 3: pulse mode
      mode = 2'b01; pulse_width = 8'h40;
      sync_load(16'h0100);
      cnt_a = 0; cnt_b = 0;
      for (int k = 1; k <= 256; k++) begin
         get_sample(w, wr, n);
         if (w == 8'hFF) cnt_a++;
         else if (w == 8'h00) cnt_b++;
         if (k == 63) check("pulse_p63", 32'(w), 32'hFF);
         if (k == 64) check("pulse_p64", 32'(w), 32'h00);
      end
      check("pulse_high", 32'(cnt_a), 32'd64);
      check("pulse_low", 32'(cnt_b), 32'd192);
      pulse_width = 8'h00;
      err = 0;
      for (int k = 0; k < 256; k++) begin
         get_sample(w, wr, n);
         if (w != 8'h00) err++;
      end
      check("pulse_pw0", 32'(err), 32'd0);

      // 4: triangle, expected sweep queued up front
      mode = 2'b10;
      for (int k = 1; k <= 256; k++) begin
         int pp;
         pp = k % 256;
         exp_q.push_back((pp < 128) ? WIDTH'(2 * pp) : WIDTH'(255 - 2 * (pp - 128)));
      end
      sync_load(16'h0100);
      err = 0; cnt_a = 0;
      for (int k = 1; k <= 256; k++) begin
         get_sample(w, wr, n);
         ex = exp_q.pop_front();
         if (w != ex) err++;
         if (w == 8'hFF) cnt_a++;
         if (k == 128) check("tri_peak", 32'(w), 32'hFF);
         if (k == 256) check("tri_floor", 32'(w), 32'h00);
      end
      check("tri_sweep", 32'(err), 32'd0);
      check("tri_peak_once", 32'(cnt_a), 32'd1);

      // ramp-down
      mode = 2'b11;
      sync_load(16'h0100);
      get_sample(w, wr, n);
      check("ramp_s1", 32'(w), 32'hFE);
      get_sample(w, wr, n);
      check("ramp_s2", 32'(w), 32'hFD);

      // 5: sync + load on the cycle a tick would fire
      mode = 2'b00;
      sync_load(16'h0100);
      for (int k = 0; k < 10; k++) get_sample(w, wr, n);
      check("sync_pre", 32'(w), 32'h0A);
      @(negedge clk);
      @(negedge clk);
      sync = 1'b1; load = 1'b1; freq_word = 16'h0400;
      @(negedge clk);
      sync = 1'b0; load = 1'b0;
      check("sync_no_tick", 32'(sample_tick), 32'h0);
      check("sync_no_wrap", 32'(wrap), 32'h0);
      get_sample(w, wr, n);
      check("sync_first", 32'(w), 32'h04);
      check("sync_first_wrap", 32'(wr), 32'h0);
      get_sample(w, wr, n);
      check("sync_second", 32'(w), 32'h08);

      // 6: freeze with enable low, then reset drops a pending load
      enable = 1'b0;
      err = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (wave_out != 8'h08 || sample_tick) err++;
      end
      check("freeze_hold", 32'(err), 32'd0);
      enable = 1'b1;
      get_sample(w, wr, n);
      check("freeze_resume", 32'(w), 32'h0C);
      pulse_load(16'h1000);
      nRst = 1'b0;
      #1;
      check("mid_rst_wave", 32'(wave_out), 32'h0);
      check("mid_rst_tick", 32'(sample_tick), 32'h0);
      @(negedge clk);
      @(negedge clk);
      nRst = 1'b1;
      err = 0;
      for (int k = 0; k < 3; k++) begin
         get_sample(w, wr, n);
         if (w != 8'h00 || wr) err++;
      end
      check("rst_drops_pending", 32'(err), 32'd0);

      // final report
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
